// File: rtl/gsim_banded_solver.sv
// Gauss-Seidel solver for the fixed 7-band symmetric system (diagonal 20, bands -13/6/-1).
// Loads N b samples, runs up to MAX_ITER sweeps, then streams x[0..N-1] out.
module gsim_banded_solver #(
  parameter int N          = 16,
  parameter int B_W        = 16,
  parameter int FRAC       = 16,
  parameter int ACC_W      = 48,
  parameter int X_W        = 32,
  parameter int MAX_ITER   = 50,
  parameter int EARLY_STOP = 0,
  parameter logic [ACC_W-1:0] TOL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic signed [B_W-1:0] b_in,
  output logic                  busy,
  output logic                  out_valid,
  output logic [X_W-1:0]        x_out,
  output logic [7:0]            iter_out
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);
  localparam logic signed [AW+1:0] N_S = (AW+2)'(N);
  localparam logic [7:0] SWEEP_MAX = 8'(MAX_ITER);
  localparam logic signed [ACC_W-1:0] C6  = ACC_W'(6);
  localparam logic signed [ACC_W-1:0] C13 = ACC_W'(13);

  typedef enum logic [2:0] {RECV, SUM, UPD, CHECK, SEND} state_t;

  state_t                  state_reg;
  logic [AW-1:0]           cnt_reg;
  logic [AW-1:0]           row_reg;
  logic [AW-1:0]           oidx_reg;
  logic [7:0]              sweep_reg;
  logic                    sent_all_reg;
  logic signed [ACC_W-1:0] theta_reg;
  logic [ACC_W-1:0]        maxd_reg;
  logic signed [ACC_W-1:0] x_mem [N];
  logic signed [B_W-1:0]   b_mem [N];
  logic signed [B_W-1:0]   b_rd_reg;

  // b buffer behaves as a RAM: written during load, read during SUM so UPD sees b[i]
  always_ff @(posedge clk) begin
    if (state_reg == RECV && in_en) begin
      b_mem[cnt_reg] <= b_in;
    end
    b_rd_reg <= b_mem[row_reg];
  end

  // Neighbour taps at offsets -3,-2,-1,+1,+2,+3; out-of-range rows read as zero
  logic signed [ACC_W-1:0] tap [6];
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_tap
      localparam int OFF = (gi < 3) ? gi - 3 : gi - 2;
      logic signed [AW+1:0] idx;
      assign idx = $signed({2'b00, row_reg}) + (AW+2)'(OFF);
      assign tap[gi] = (!idx[AW+1] && idx < N_S) ? x_mem[idx[AW-1:0]] : '0;
    end
  endgenerate

  logic signed [ACC_W-1:0] theta_next;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] num;
  logic signed [ACC_W-1:0] xn;
  logic signed [ACC_W-1:0] diff;
  logic [ACC_W-1:0]        absd;
  logic [7:0]              sweep_next;

  assign theta_next = C6 * (tap[1] + tap[4]) - C13 * (tap[2] + tap[3]) - (tap[0] + tap[5]);
  assign b_ext      = ACC_W'(b_rd_reg);
  assign num        = (b_ext <<< FRAC) - theta_reg;

  // Divide by 20 as a truncated shift sum: shifts 5,6,9,10,...,29,30
  logic signed [ACC_W-1:0] dterm [14];
  generate
    for (gi = 0; gi < 14; gi++) begin : g_div
      localparam int SH = 4 * (gi / 2) + 5 + (gi % 2);
      assign dterm[gi] = num >>> SH;
    end
  endgenerate

  always_comb begin
    xn = '0;
    for (int t = 0; t < 14; t++) begin
      xn = xn + dterm[t];
    end
  end

  assign diff       = xn - x_mem[row_reg];
  assign absd       = diff[ACC_W-1] ? ACC_W'(-diff) : diff;
  assign sweep_next = sweep_reg + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RECV;
      cnt_reg      <= '0;
      row_reg      <= '0;
      oidx_reg     <= '0;
      sweep_reg    <= '0;
      sent_all_reg <= 1'b0;
      theta_reg    <= '0;
      maxd_reg     <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      x_out        <= '0;
      iter_out     <= '0;
      for (int r = 0; r < N; r++) begin
        x_mem[r] <= '0;
      end
    end else begin
      case (state_reg)
        RECV: begin
          if (in_en) begin
            if (cnt_reg == LAST_ROW) begin
              cnt_reg   <= '0;
              busy      <= 1'b1;
              row_reg   <= '0;
              sweep_reg <= '0;
              for (int r = 0; r < N; r++) begin
                x_mem[r] <= '0;
              end
              state_reg <= SUM;
            end else begin
              cnt_reg <= cnt_reg + AW'(1);
            end
          end
        end
        SUM: begin
          theta_reg <= theta_next;
          state_reg <= UPD;
        end
        UPD: begin
          x_mem[row_reg] <= xn;
          // row 0 restarts the per-sweep maximum
          maxd_reg <= (row_reg == '0 || absd > maxd_reg) ? absd : maxd_reg;
          if (row_reg == LAST_ROW) begin
            state_reg <= CHECK;
          end else begin
            row_reg   <= row_reg + AW'(1);
            state_reg <= SUM;
          end
        end
        CHECK: begin
          sweep_reg <= sweep_next;
          if (sweep_next == SWEEP_MAX || (EARLY_STOP != 0 && maxd_reg <= TOL)) begin
            iter_out     <= sweep_next;
            oidx_reg     <= '0;
            sent_all_reg <= 1'b0;
            state_reg    <= SEND;
          end else begin
            row_reg   <= '0;
            state_reg <= SUM;
          end
        end
        SEND: begin
          if (!sent_all_reg) begin
            out_valid <= 1'b1;
            x_out     <= x_mem[oidx_reg][X_W-1:0];
            if (oidx_reg == LAST_ROW) begin
              sent_all_reg <= 1'b1;
            end else begin
              oidx_reg <= oidx_reg + AW'(1);
            end
          end else begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RECV;
          end
        end
        default: state_reg <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_banded_solver.sv
// Directed bench for gsim_banded_solver: four configurations sharing clk/reset,
// checked against hand values and a straightforward Gauss-Seidel model.
module tb_gsim_banded_solver;

  logic clk = 1'b0;
  logic reset;
  logic              in_en_v    [4];
  logic signed [15:0] b_in_v    [4];
  logic              busy_v     [4];
  logic              out_valid_v[4];
  logic [31:0]       x_out_v    [4];
  logic [7:0]        iter_out_v [4];

  always #5 clk = ~clk;

  gsim_banded_solver #(.N(4), .MAX_ITER(1)) u_small (
    .clk(clk), .reset(reset), .in_en(in_en_v[0]), .b_in(b_in_v[0]),
    .busy(busy_v[0]), .out_valid(out_valid_v[0]), .x_out(x_out_v[0]), .iter_out(iter_out_v[0]));

  gsim_banded_solver u_dflt (
    .clk(clk), .reset(reset), .in_en(in_en_v[1]), .b_in(b_in_v[1]),
    .busy(busy_v[1]), .out_valid(out_valid_v[1]), .x_out(x_out_v[1]), .iter_out(iter_out_v[1]));

  gsim_banded_solver #(.EARLY_STOP(1), .TOL(48'd0)) u_es0 (
    .clk(clk), .reset(reset), .in_en(in_en_v[2]), .b_in(b_in_v[2]),
    .busy(busy_v[2]), .out_valid(out_valid_v[2]), .x_out(x_out_v[2]), .iter_out(iter_out_v[2]));

  gsim_banded_solver #(.EARLY_STOP(1), .TOL(48'd4)) u_es4 (
    .clk(clk), .reset(reset), .in_en(in_en_v[3]), .b_in(b_in_v[3]),
    .busy(busy_v[3]), .out_valid(out_valid_v[3]), .x_out(x_out_v[3]), .iter_out(iter_out_v[3]));

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] bv [64];
  logic signed [47:0] mx [64];
  int                 m_iter;
  logic [31:0]        cap_x [64];
  logic [31:0]        clean_x [64];
  logic [7:0]         cap_iter;
  int                 cap_lat;
  int                 cap_cnt;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [47:0] mdiv20(input logic signed [47:0] v);
    logic signed [47:0] acc;
    acc = '0;
    for (int s = 5; s <= 30; s++) begin
      if ((s % 4) == 1 || (s % 4) == 2) acc = acc + (v >>> s);
    end
    return acc;
  endfunction

  task automatic model(input int n, input int max_iter, input bit es, input longint tol);
    int cf[7] = '{-1, 6, -13, 0, -13, 6, -1};
    longint theta, maxd, d;
    logic signed [47:0] num, xn;
    for (int i = 0; i < 64; i++) mx[i] = '0;
    m_iter = 0;
    for (int k = 1; k <= max_iter; k++) begin
      maxd = 0;
      for (int i = 0; i < n; i++) begin
        theta = 0;
        for (int o = -3; o <= 3; o++) begin
          if (i + o >= 0 && i + o < n) theta += cf[o+3] * longint'(mx[i+o]);
        end
        num = 48'((longint'(bv[i]) <<< 16) - theta);
        xn  = mdiv20(num);
        d   = longint'(xn) - longint'(mx[i]);
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
        mx[i] = xn;
      end
      m_iter = k;
      if (es && maxd <= tol) break;
    end
  endtask

  // Called on a negedge; returns on the negedge just after the edge that took sample n-1.
  task automatic load_vec(input int d, input int n, input int gap);
    for (int s = 0; s < n; s++) begin
      if (s > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_en_v[d] = 1'b0;
          b_in_v[d]  = 16'sh5A5A;
          @(negedge clk);
        end
      end
      in_en_v[d] = 1'b1;
      b_in_v[d]  = bv[s];
      @(negedge clk);
    end
    in_en_v[d] = 1'b0;
  endtask

  task automatic run_dut(input int d, input int n, input int gap, input bit junk,
                         input int exp_lat, input int exp_iter, input string tag);
    load_vec(d, n, gap);
    check({tag, "_busy_rise"}, 64'(busy_v[d]), 64'sd1);
    cap_lat = 0;
    in_en_v[d] = junk;
    while (out_valid_v[d] !== 1'b1 && cap_lat < 20000) begin
      if (junk) b_in_v[d] = 16'($urandom);
      @(negedge clk);
      cap_lat++;
    end
    check({tag, "_latency"}, 64'(cap_lat), 64'(exp_lat));
    cap_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (out_valid_v[d] === 1'b1) cap_cnt++;
      cap_x[i] = x_out_v[d];
      cap_iter = iter_out_v[d];
      if (junk) b_in_v[d] = 16'($urandom);
      @(negedge clk);
    end
    in_en_v[d] = 1'b0;
    check({tag, "_valid_cycles"}, 64'(cap_cnt), 64'(n));
    check({tag, "_valid_fall"}, 64'(out_valid_v[d]), 64'sd0);
    check({tag, "_busy_fall"}, 64'(busy_v[d]), 64'sd0);
    check({tag, "_iter"}, 64'(cap_iter), 64'(exp_iter));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_x%0d", tag, i), 64'($signed(cap_x[i])), 64'($signed(mx[i][31:0])));
    end
    $display("%s: n=%0d latency=%0d iter=%0d x0=%0d", tag, n, cap_lat, cap_iter, $signed(cap_x[0]));
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      in_en_v[d] = 1'b0;
      b_in_v[d]  = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy_v[0]), 64'sd0);
    check("reset_valid", 64'(out_valid_v[0]), 64'sd0);
    check("reset_x", 64'(x_out_v[1]), 64'sd0);
    check("reset_iter", 64'(iter_out_v[1]), 64'sd0);
    reset = 1'b0;
    @(negedge clk);

    // N=4, one sweep, b = {20,0,0,0}
    for (int i = 0; i < 64; i++) bv[i] = '0;
    bv[0] = 16'sd20;
    model(4, 1, 1'b0, 0);
    run_dut(0, 4, 0, 1'b0, 10, 1, "small");
    check("small_hand_x0", 64'($signed(cap_x[0])), 64'sd65535);
    check("small_hand_x1", 64'($signed(cap_x[1])), 64'sd42591);
    check("small_hand_x2", 64'($signed(cap_x[2])), 64'sd8019);
    check("small_hand_x3", 64'($signed(cap_x[3])), -64'sd4299);

    // all-zero b with early stop, TOL=0: one sweep
    for (int i = 0; i < 64; i++) bv[i] = '0;
    model(16, 50, 1'b1, 0);
    run_dut(2, 16, 0, 1'b0, 34, 1, "zero_es");

    // random b, full 50 sweeps
    for (int i = 0; i < 16; i++) bv[i] = 16'($urandom);
    model(16, 50, 1'b0, 0);
    run_dut(1, 16, 0, 1'b0, 1651, 50, "rand");
    for (int i = 0; i < 16; i++) clean_x[i] = cap_x[i];

    // same b with load gaps and junk while busy
    run_dut(1, 16, 3, 1'b1, 1651, 50, "gaps");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("gaps_vs_clean_x%0d", i), 64'($signed(cap_x[i])), 64'($signed(clean_x[i])));
    end

    // reset during SUM of sweep 7 (row 2)
    load_vec(1, 16, 0);
    repeat (7 * 33 + 4) @(negedge clk);
    check("pre_rst_busy", 64'(busy_v[1]), 64'sd1);
    reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy_v[1]), 64'sd0);
    check("rst_valid", 64'(out_valid_v[1]), 64'sd0);
    check("rst_x", 64'(x_out_v[1]), 64'sd0);
    check("rst_iter", 64'(iter_out_v[1]), 64'sd0);
    $display("reset mid-sweep applied");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_dut(1, 16, 0, 1'b0, 1651, 50, "after_rst");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rst_vs_clean_x%0d", i), 64'($signed(cap_x[i])), 64'($signed(clean_x[i])));
    end

    // smooth b with early stop at TOL=4
    for (int i = 0; i < 16; i++) bv[i] = 16'sd1;
    model(16, 50, 1'b1, 4);
    run_dut(3, 16, 0, 1'b0, m_iter * 33 + 1, m_iter, "es4");
    check("es4_iter_below_max", 64'(cap_iter < 8'd50), 64'sd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
